// File: rtl/sample_frame_loader_if.sv
// Stream-in / memory-write bundle for the sample frame loader.
interface sample_frame_loader_if #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 2
);
    logic signed [BITS-1:0]     sample_in;
    logic                       sample_valid;
    logic                       sample_ready;
    logic signed [BITS-1:0]     offset;
    logic [ADDRESS_BITS-1:0]    write_address;
    logic signed [BITS-1:0]     write_data;
    logic                       write_enable;
    logic                       frame_done;
    logic                       frame_release;
    logic [ADDRESS_BITS:0]      sample_count;
    logic                       sat_event;

    modport slave (
        input  sample_in, sample_valid, offset, frame_release,
        output sample_ready, write_address, write_data, write_enable,
        output frame_done, sample_count, sat_event
    );

    modport master (
        output sample_in, sample_valid, offset, frame_release,
        input  sample_ready, write_address, write_data, write_enable,
        input  frame_done, sample_count, sat_event
    );
endinterface

// File: rtl/sample_frame_loader.sv
// Offset-removing, saturating sample loader filling one Memory frame
// per handshake cycle; holds the full frame until the consumer releases it.
module sample_frame_loader #(
    parameter int BITS                = 16,
    parameter int ADDRESS_BITS        = 2,
    parameter int NUMBER_OF_LOCATIONS = 4
) (
    input logic clk,
    input logic rst,
    sample_frame_loader_if.slave bus
);
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [ADDRESS_BITS:0] LAST =
        (ADDRESS_BITS+1)'(NUMBER_OF_LOCATIONS - 1);

    state_t state;
    state_t state_next;

    logic [ADDRESS_BITS:0] count;
    logic                  accept;
    logic                  last;
    logic signed [BITS:0]  diff;
    logic                  sat_hi;
    logic                  sat_lo;
    logic signed [BITS-1:0] result;

    assign bus.sample_ready = (state == FILL);
    assign bus.sample_count = count;
    assign accept = bus.sample_valid && (state == FILL);
    assign last   = (count == LAST);

    // One extra bit holds the exact difference; its top two bits disagree on overflow
    assign diff = {bus.sample_in[BITS-1], bus.sample_in}
                - {bus.offset[BITS-1], bus.offset};
    assign sat_hi = !diff[BITS] && diff[BITS-1];
    assign sat_lo = diff[BITS] && !diff[BITS-1];

    always_comb begin
        result = diff[BITS-1:0];
        if (sat_hi) begin
            result = {1'b0, {(BITS-1){1'b1}}};
        end else if (sat_lo) begin
            result = {1'b1, {(BITS-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FILL: begin
                if (accept && last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = FULL;
            end
            FULL: begin
                if (bus.frame_release) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count             <= '0;
            bus.write_address <= '0;
            bus.write_data    <= '0;
            bus.write_enable  <= 1'b0;
            bus.sat_event     <= 1'b0;
            bus.frame_done    <= 1'b0;
        end else begin
            bus.write_enable <= accept;
            bus.sat_event    <= accept && (sat_hi || sat_lo);
            bus.frame_done   <= (state_next == FULL);
            if (accept) begin
                bus.write_address <= count[ADDRESS_BITS-1:0];
                bus.write_data    <= result;
                count             <= count + 1'b1;
            end else if (state == FULL && bus.frame_release) begin
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sample_frame_loader.sv
// Directed bench for sample_frame_loader: table of arithmetic vectors
// plus hand-written reset, frame, gap, release and flush sequences.
module tb_sample_frame_loader;
    localparam int BITS = 16;
    localparam int AB   = 2;
    localparam int N    = 4;

    typedef struct {
        logic signed [15:0] smp;
        logic signed [15:0] off;
        logic signed [15:0] exp_data;
        logic               exp_sat;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic signed [15:0] mem [N];

    sample_frame_loader_if #(.BITS(BITS), .ADDRESS_BITS(AB)) bus ();

    sample_frame_loader #(
        .BITS(BITS),
        .ADDRESS_BITS(AB),
        .NUMBER_OF_LOCATIONS(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.write_enable) begin
            mem[bus.write_address] <= bus.write_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ensure_ready();
        int n;
        n = 0;
        while (!bus.sample_ready && n < 20) begin
            if (bus.frame_done) begin
                bus.frame_release = 1'b1;
                step();
                bus.frame_release = 1'b0;
            end else begin
                step();
            end
            n++;
        end
        chk("ready_wait", {31'b0, bus.sample_ready}, 32'd1);
    endtask

    task automatic send(input logic signed [15:0] s,
                        input logic signed [15:0] o);
        bus.sample_in    = s;
        bus.offset       = o;
        bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
    endtask

    vec_t vecs [12];
    int   addr_model;
    logic signed [15:0] basic_s [4];
    logic signed [15:0] basic_e [4];
    logic [6:0] gap_pat;
    int   gap_idx;

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        vecs[0]  = '{16'sd42,     16'sd10,     16'sd32,     1'b0};
        vecs[1]  = '{16'sd15,     16'sd10,     16'sd5,      1'b0};
        vecs[2]  = '{16'sd10,     16'sd10,     16'sd0,      1'b0};
        vecs[3]  = '{-16'sd90,    16'sd10,     -16'sd100,   1'b0};
        vecs[4]  = '{16'sd32767,  -16'sd1,     16'sd32767,  1'b1};
        vecs[5]  = '{-16'sd32768, 16'sd1,      -16'sd32768, 1'b1};
        vecs[6]  = '{16'sd5,      16'sd0,      16'sd5,      1'b0};
        vecs[7]  = '{-16'sd32768, 16'sd32767,  -16'sd32768, 1'b1};
        vecs[8]  = '{16'sd32767,  -16'sd32768, 16'sd32767,  1'b1};
        vecs[9]  = '{16'sd100,    -16'sd200,   16'sd300,    1'b0};
        vecs[10] = '{-16'sd1,     -16'sd1,     16'sd0,      1'b0};
        vecs[11] = '{16'sd32766,  -16'sd1,     16'sd32767,  1'b0};
        basic_s = '{16'sd42, 16'sd15, 16'sd10, -16'sd90};
        basic_e = '{16'sd32, 16'sd5, 16'sd0, -16'sd100};

        rst = 1'b0;
        bus.sample_in     = '0;
        bus.offset        = '0;
        bus.sample_valid  = 1'b0;
        bus.frame_release = 1'b0;
        step();
        step();
        chk("rst_we",    {31'b0, bus.write_enable}, 32'd0);
        chk("rst_done",  {31'b0, bus.frame_done},   32'd0);
        chk("rst_ready", {31'b0, bus.sample_ready}, 32'd1);
        chk("rst_count", {29'b0, bus.sample_count}, 32'd0);
        chk("rst_wd",    {16'b0, bus.write_data},   32'd0);
        rst = 1'b1;
        step();

        // reset with two samples accepted and a write pending
        send(16'sd1, 16'sd0);
        send(16'sd2, 16'sd0);
        chk("pre_rst_we", {31'b0, bus.write_enable}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_we",    {31'b0, bus.write_enable}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.sample_ready}, 32'd1);
        chk("mid_rst_count", {29'b0, bus.sample_count}, 32'd0);
        chk("mid_rst_addr",  {30'b0, bus.write_address}, 32'd0);
        chk("mid_rst_wd",    {16'b0, bus.write_data},   32'd0);
        step();
        rst = 1'b1;
        step();

        // back-to-back basic frame
        bus.offset = 16'sd10;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sample_in = basic_s[i];
            step();
            chk("basic_we",   {31'b0, bus.write_enable}, 32'd1);
            chk("basic_addr", {30'b0, bus.write_address}, i);
            chk("basic_data", bus.write_data, basic_e[i]);
        end
        bus.sample_in = 16'sd999;
        chk("flush_ready", {31'b0, bus.sample_ready}, 32'd0);
        chk("flush_done",  {31'b0, bus.frame_done},   32'd0);
        step();
        chk("full_done",  {31'b0, bus.frame_done},   32'd1);
        chk("full_we",    {31'b0, bus.write_enable}, 32'd0);
        chk("full_count", {29'b0, bus.sample_count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_mem", mem[i], basic_e[i]);
        end
        // valid held while FULL must not write
        for (int i = 0; i < 4; i++) begin
            step();
            chk("full_idle_we", {31'b0, bus.write_enable}, 32'd0);
            chk("full_hold",    {31'b0, bus.frame_done},   32'd1);
        end
        bus.sample_valid = 1'b0;
        chk("full_mem3", mem[3], -16'sd100);

        bus.frame_release = 1'b1;
        step();
        bus.frame_release = 1'b0;
        chk("rel_done",  {31'b0, bus.frame_done},   32'd0);
        chk("rel_ready", {31'b0, bus.sample_ready}, 32'd1);
        chk("rel_count", {29'b0, bus.sample_count}, 32'd0);
        send(16'sd7, 16'sd0);
        chk("rel_addr", {30'b0, bus.write_address}, 32'd0);
        chk("rel_data", bus.write_data, 16'sd7);
        bus.frame_release = 1'b1;
        step();
        bus.frame_release = 1'b0;
        chk("fill_rel_count", {29'b0, bus.sample_count}, 32'd1);
        chk("fill_rel_ready", {31'b0, bus.sample_ready}, 32'd1);
        addr_model = 1;

        for (int i = 0; i < 12; i++) begin
            ensure_ready();
            send(vecs[i].smp, vecs[i].off);
            chk("vec_we",   {31'b0, bus.write_enable}, 32'd1);
            chk("vec_addr", {30'b0, bus.write_address}, addr_model);
            chk("vec_data", bus.write_data, vecs[i].exp_data);
            chk("vec_sat",  {31'b0, bus.sat_event}, {31'b0, vecs[i].exp_sat});
            addr_model = (addr_model + 1) % N;
        end
        step();
        chk("sat_clear", {31'b0, bus.sat_event}, 32'd0);

        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // gaps in valid: 1,0,0,1,1,0,1
        gap_pat = 7'b1011001;
        gap_idx = 0;
        bus.offset = 16'sd0;
        for (int j = 0; j < 7; j++) begin
            bus.sample_valid = gap_pat[j];
            bus.sample_in = 16'(100 + j);
            step();
            chk("gap_we", {31'b0, bus.write_enable}, {31'b0, gap_pat[j]});
            if (gap_pat[j]) begin
                chk("gap_addr", {30'b0, bus.write_address}, gap_idx);
                gap_idx++;
            end
        end
        bus.sample_valid = 1'b0;
        step();
        chk("gap_done", {31'b0, bus.frame_done}, 32'd1);
        chk("gap_mem3", mem[3], 16'sd106);
        chk("gap_mem1", mem[1], 16'sd103);

        // reset while the last write is pending in FLUSH
        bus.frame_release = 1'b1;
        step();
        bus.frame_release = 1'b0;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sample_in = 16'(200 + i);
            step();
        end
        bus.sample_valid = 1'b0;
        chk("flush_we_pre", {31'b0, bus.write_enable}, 32'd1);
        rst = 1'b0;
        #1;
        chk("flush_rst_we", {31'b0, bus.write_enable}, 32'd0);
        step();
        chk("flush_rst_mem3", mem[3], 16'sd106);
        chk("flush_rst_mem2", mem[2], 16'sd202);
        rst = 1'b1;
        step();
        chk("flush_rst_ready", {31'b0, bus.sample_ready}, 32'd1);
        chk("flush_rst_done",  {31'b0, bus.frame_done},   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
